// File: rtl/ifns_serial_encoder_if.sv
// Handshake bundle between the data source, the IFNS serial encoder and the bus driver.
interface ifns_serial_encoder_if;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CW_W   = 17;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW_W-1:0]   out_cw;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_cw
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_cw
  );
endinterface

// File: rtl/ifns_serial_encoder.sv
// Binary-to-IFNS encoder: MSB-first greedy compare-subtract, one codeword bit per cycle.
// Optional accumulator self-check enabled by IFNS_ENC_SELFCHECK_EN (adds chk_err).
module ifns_serial_encoder (
  input  logic                        clk,
  input  logic                        rst_n,
  ifns_serial_encoder_if.slave        bus,
`ifdef IFNS_ENC_SELFCHECK_EN
  output logic                        chk_err,
`endif
  output logic                        busy
);
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CW_W   = 17;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned ACC_W  = 13;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(CW_W - 1);

  // Weight of codeword bit k; the top bit skips 1597 and carries 2584.
  localparam logic [DATA_W-1:0] WEIGHT [0:CW_W-1] = '{
    12'd1,   12'd1,   12'd2,   12'd3,   12'd5,   12'd8,   12'd13,  12'd21,  12'd34,
    12'd55,  12'd89,  12'd144, 12'd233, 12'd377, 12'd610, 12'd987, 12'd2584
  };

  typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic [CW_W-1:0]     out_cw_q, out_cw_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   weight_c;
  logic                take_c;
`ifdef IFNS_ENC_SELFCHECK_EN
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   orig_q, orig_d;
  logic                chk_err_q, chk_err_d;
`endif

  assign weight_c = WEIGHT[idx_q];
  assign take_c   = (res_q >= weight_c);

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    idx_d     = idx_q;
    cw_d      = cw_q;
    out_cw_d  = out_cw_q;
`ifdef IFNS_ENC_SELFCHECK_EN
    acc_d     = acc_q;
    orig_d    = orig_q;
    chk_err_d = chk_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          res_d   = bus.in_data;
          idx_d   = IDX_TOP;
          cw_d    = '0;
          state_d = ST_ENC;
`ifdef IFNS_ENC_SELFCHECK_EN
          acc_d   = '0;
          orig_d  = bus.in_data;
`endif
        end
      end
      ST_ENC: begin
        cw_d[idx_q] = take_c;
        if (take_c) begin
          res_d = res_q - weight_c;
`ifdef IFNS_ENC_SELFCHECK_EN
          acc_d = acc_q + ACC_W'(weight_c);
`endif
        end
        if (idx_q == '0) begin
          out_cw_d = cw_d;
          state_d  = ST_DONE;
`ifdef IFNS_ENC_SELFCHECK_EN
          if ((acc_d != ACC_W'(orig_q)) || (res_d != '0)) chk_err_d = 1'b1;
`endif
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      res_q       <= '0;
      idx_q       <= IDX_TOP;
      cw_q        <= '0;
      out_cw_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      cw_q        <= cw_d;
      out_cw_q    <= out_cw_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef IFNS_ENC_SELFCHECK_EN
  // Shadow sum and original value; chk_err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      orig_q    <= '0;
      chk_err_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      orig_q    <= orig_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cw    = out_cw_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_ifns_serial_encoder.sv
// Self-checking bench for ifns_serial_encoder: directed corners plus a full input sweep
// against a greedy Fibonacci reference model.
module tb_ifns_serial_encoder;
  logic clk;
  logic rst_n;
  logic busy;
`ifdef IFNS_ENC_SELFCHECK_EN
  logic chk_err;
`endif

  ifns_serial_encoder_if bus ();

  ifns_serial_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
`ifdef IFNS_ENC_SELFCHECK_EN
    .chk_err (chk_err),
`endif
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int t_acc  = 0;
  int wgt [0:16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fibonacci weights; the top position jumps two terms ahead.
  task automatic build_weights();
    int fib [0:17];
    fib[0] = 1;
    fib[1] = 1;
    for (int k = 2; k < 18; k++) fib[k] = fib[k-1] + fib[k-2];
    for (int k = 0; k < 16; k++) wgt[k] = fib[k];
    wgt[16] = fib[17];
  endtask

  function automatic logic [16:0] model_enc(input int v);
    logic [16:0] cw;
    int rem;
    cw  = '0;
    rem = v;
    for (int k = 16; k >= 0; k--) begin
      if (rem >= wgt[k]) begin
        cw[k] = 1'b1;
        rem   = rem - wgt[k];
      end
    end
    return cw;
  endfunction

  function automatic int decode(input logic [16:0] cw);
    int s;
    s = 0;
    for (int k = 0; k < 17; k++) if (cw[k]) s += wgt[k];
    return s;
  endfunction

  // Offer a value at a negedge and wait for the accepting edge.
  task automatic send(input int v);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 12'(v);
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("send_timeout", 32'(bus.in_ready), 32'd1);
    t_acc = cyc + 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Wait for the codeword, check it, optionally stall, then hand it off.
  task automatic get(input int v, input logic [16:0] exp_cw, input int stall, input string tag);
    int n;
    logic [16:0] held;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'(cyc - t_acc), 32'd17);
    chk({tag, "_cw"}, 32'(bus.out_cw), 32'(exp_cw));
    chk({tag, "_sum"}, 32'(decode(bus.out_cw)), 32'(v));
    held = bus.out_cw;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_cw"}, 32'(bus.out_cw), 32'(held));
      chk({tag, "_stall_rdy"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    int stall;
    build_weights();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_cw", 32'(bus.out_cw), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(4095);
    chk("busy_enc", 32'(busy), 32'd1);
    get(4095, 17'h1A808, 0, "v4095");
`ifdef IFNS_ENC_SELFCHECK_EN
    chk("chk_err_clean", 32'(chk_err), 32'd0);
`endif
    send(0);    get(0,    17'h00000, 0, "v0");
    send(1);    get(1,    17'h00002, 2, "v1");
    send(2583); get(2583, 17'h0FFFF, 0, "v2583");
    send(2584); get(2584, 17'h10000, 1, "v2584");

    // Reset in the middle of an encode.
    send(1234);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1;
    end
    chk("mid_rst_no_valid", 32'(seen), 32'd0);

    // Backpressure with a competing request held the whole time.
    send(777);
    bus.in_valid = 1'b1;
    bus.in_data  = 12'd555;
    get(777, model_enc(777), 10, "bp");
    chk("bp_ready_after", 32'(bus.in_ready), 32'd1);
    send(555);
    get(555, model_enc(555), 0, "bp_next");

    // Exhaustive round trip with occasional stalls.
    for (int v = 0; v < 4096; v++) begin
      stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      send(v);
      get(v, model_enc(v), stall, "sweep");
    end

`ifdef IFNS_ENC_SELFCHECK_EN
    chk("chk_err_after_sweep", 32'(chk_err), 32'd0);
    send(100);
    repeat (3) @(negedge clk);
    force dut.res_q = 12'd4000;
    @(negedge clk);
    release dut.res_q;
    seen = 0;
    while (bus.out_valid !== 1'b1 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    chk("corrupt_chk_err", 32'(chk_err), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(5);
    get(5, model_enc(5), 0, "post_corrupt");
    chk("chk_err_sticky", 32'(chk_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("chk_err_rst", 32'(chk_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
